mc_core_param: RTL and testbench
================================

Name: mc_core_param

Overview:
- Parametrised multicycle load/store core; next generation of the team's 16-bit multicycle processor.
- Generalised in datapath width, register count and reset vector.
- Adds a ready-based memory handshake with wait states, which the previous core lacks (it assumed single-cycle memories).
- Single unified word-addressed memory port; instructions fixed at 16 bits.

Parameters:
DW, 16, datapath/register width in bits; legal range 16..64.
AW, 16, memory address/PC width in bits; AW <= DW.
NREG, 16, register count (2, 4, 8 or 16); register index = field[log2(NREG)-1:0]; r0 reads 0, writes ignored.
RESET_PC, 0, PC value after reset.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-low reset
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write (SW), 0 = read
mem_addr  out  AW  word address
mem_wdata  out  DW  store data
mem_rdata  in  DW  read data; instruction = mem_rdata[15:0]
mem_ready  in  1  transaction completes on an edge where mem_req & mem_ready
halted  out  1  core stopped on HALT
state_dbg  out  3  current FSM state encoding
perf_cycles  out  32  cycle counter (see Optional Feature)
perf_retired  out  32  retired-instruction counter (see Optional Feature)

Behaviour:
- ISA, op = IR[15:12], a = IR[11:8], b = IR[7:4], c = IR[3:0]:
  - 0 ADD: Ra = Rb + Rc
  - 1 SUB: Ra = Rb - Rc
  - 2 AND: Ra = Rb & Rc
  - 3 OR: Ra = Rb | Rc
  - 4 ADDI: Ra = Ra + sext(IR[7:0])
  - 5 LW: Ra = mem[Rb[AW-1:0]]
  - 6 SW: mem[Rb[AW-1:0]] = Ra
  - 7 BEQZ: if Ra == 0, PC = PC + sext(IR[7:0])
  - 8 BNEZ: if Ra != 0, PC = PC + sext(IR[7:0])
  - 9 JMP: PC = PC + sext(IR[11:0])
  - F HALT
  - A-E: NOP
- Branch targets are relative to the already-incremented PC (address of the next instruction).
- Arithmetic is modulo 2^DW; PC arithmetic is modulo 2^AW and wraps silently.
- States (state_dbg): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Held with stable address until mem_ready.
  - On completion: IR <= rdata[15:0], PC <= PC+1, go to DECODE.
- DECODE: latch A = R[b], B = R[c] (for ADDI/SW/branches: A = R[a]); go to EXEC.
- EXEC:
  - ALU ops compute into ALUOut and go to WB.
  - LW/SW put the address into ALUOut and go to MEM.
  - Branches/JMP update PC if taken, then go to FETCH.
  - NOP goes to FETCH.
  - HALT goes to HALT.
- MEM:
  - mem_req=1, mem_addr=ALUOut.
  - SW: mem_we=1, mem_wdata=R[a].
  - Held until mem_ready.
  - SW then goes to FETCH; LW latches rdata into MDR and goes to WB.
- WB: write ALUOut or MDR to Ra (skipped if Ra is r0); go to FETCH.
- HALT:
  - halted=1, no mem_req; exited only by reset.
  - HALT retires on entry (perf_retired increments once).
- Zero-wait-state latency, in cycles:
  - ALU/ADDI: 4
  - LW: 5
  - SW: 4
  - branch/JMP/NOP: 3
  - each wait cycle (mem_ready=0 while mem_req=1) adds 1
- Outside FETCH and MEM: mem_req=0, mem_we=0; mem_addr and mem_wdata hold their last value.
- Reset (async, rst=0):
  - state=FETCH, PC=RESET_PC, all registers/IR/MDR/ALUOut = 0.
  - mem_req=0, mem_we=0, halted=0, counters=0.
  - Reset asserted mid-transaction drops mem_req immediately; the transaction is abandoned and no register/PC update occurs.
  - First FETCH request is issued in the first cycle after rst deasserts.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
MC_CORE_PERF_EN
- Defined:
  - perf_cycles increments every cycle while not halted.
  - perf_retired increments once per completed instruction (on the final-state transition).
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset vector: RESET_PC=16'h0010, rst pulse -> first mem_req=1 with mem_addr=0x0010, mem_we=0; state_dbg=0.
- ALU sequence, zero-wait memory: ADDI r1,5; ADDI r2,-3; ADD r3,r1,r2; HALT -> r3=2, halted after 4+4+4+3=15 cycles; perf_retired=4, perf_cycles=15 (MC_CORE_PERF_EN).
- Load/store with 2 wait states per access: r1=0x40, r2=0xBEEF; SW r2,r1; LW r4,r1 -> memory write at 0x40 with data 0xBEEF; r4=0xBEEF; mem_addr/mem_we stable through wait cycles; SW takes 8 cycles, LW 9.
- Branches: r1=0; BEQZ r1,+2 skips 2 instructions; BNEZ r1,+2 falls through; JMP -1 at 0x20 loops to 0x20 -> PC trace matches; r0 write by ADDI r0,7 leaves r0=0.
- Width/wrap: DW=32, NREG=8; ADDI r1,-1 then ADDI r1,1 -> r1 = 0xFFFFFFFF then 0; a register field value of 9 selects r1.
- Reset mid-MEM: assert rst while a SW is waiting on mem_ready=0 -> mem_req falls asynchronously; after release the core re-fetches from RESET_PC and no write is observed.

Source files
------------

// File: rtl/mc_core_param.sv
// mc_core_param: parametrised multicycle load/store core with a ready-based
// unified memory port (wait states supported).
// Optional build macro: MC_CORE_PERF_EN adds cycle/retired-instruction counters;
// without it perf_cycles/perf_retired are tied to zero.
module mc_core_param #(
  parameter int              DW       = 16,
  parameter int              AW       = 16,
  parameter int              NREG     = 16,
  parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic [2:0]    state_dbg,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_retired
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] PC_INC = {{(AW-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_BNEZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t          state_r, state_n;
  logic [AW-1:0]   pc_r, addr_hold_r, target_s;
  logic [15:0]     ir_r;
  logic [DW-1:0]   a_r, b_r, alu_out_r, mdr_r, wdata_hold_r, alu_s;
  logic [DW-1:0]   regs_r [NREG];
  logic [3:0]      op_s;
  logic [RW-1:0]   ra_s, rb_s, rc_s;
  logic            use_ra_s, taken_s;

  // Sign extension goes through a 64-bit intermediate so any legal width works.
  function automatic logic [DW-1:0] sext8_dw(input logic [7:0] v);
    logic [63:0] t;
    t = {{56{v[7]}}, v};
    return t[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] sext8_aw(input logic [7:0] v);
    logic [63:0] t;
    t = {{56{v[7]}}, v};
    return t[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] sext12_aw(input logic [11:0] v);
    logic [63:0] t;
    t = {{52{v[11]}}, v};
    return t[AW-1:0];
  endfunction

  assign op_s     = ir_r[15:12];
  assign ra_s     = ir_r[8 +: RW];
  assign rb_s     = ir_r[4 +: RW];
  assign rc_s     = ir_r[0 +: RW];
  assign use_ra_s = (op_s == OP_ADDI) || (op_s == OP_SW) ||
                    (op_s == OP_BEQZ) || (op_s == OP_BNEZ);

  // State register; reset returns to FETCH and abandons any open transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_FETCH;
    else      state_r <= state_n;
  end

  // Next-state logic; memory states wait on mem_ready.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_FETCH:  if (mem_ready) state_n = S_DECODE; else state_n = S_FETCH;
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_n = S_WB;
          OP_LW, OP_SW:                           state_n = S_MEM;
          OP_HALT:                                state_n = S_HALT;
          default:                                state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ready)         state_n = S_MEM;
        else if (op_s == OP_SW) state_n = S_FETCH;
        else                    state_n = S_WB;
      end
      S_WB:    state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // ALU result and branch target; LW/SW addresses are zero-extended into ALUOut.
  always_comb begin
    alu_s    = '0;
    taken_s  = 1'b0;
    target_s = pc_r;
    case (op_s)
      OP_ADD:  alu_s = a_r + b_r;
      OP_SUB:  alu_s = a_r - b_r;
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_ADDI: alu_s = a_r + sext8_dw(ir_r[7:0]);
      OP_LW:   alu_s[AW-1:0] = a_r[AW-1:0];
      OP_SW:   alu_s[AW-1:0] = b_r[AW-1:0];
      OP_BEQZ: begin
        taken_s  = (a_r == '0);
        target_s = pc_r + sext8_aw(ir_r[7:0]);
      end
      OP_BNEZ: begin
        taken_s  = (a_r != '0);
        target_s = pc_r + sext8_aw(ir_r[7:0]);
      end
      OP_JMP: begin
        taken_s  = 1'b1;
        target_s = pc_r + sext12_aw(ir_r[11:0]);
      end
      default: alu_s = '0;
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALUOut, MDR, register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r         <= RESET_PC;
      ir_r         <= 16'h0000;
      a_r          <= '0;
      b_r          <= '0;
      alu_out_r    <= '0;
      mdr_r        <= '0;
      addr_hold_r  <= '0;
      wdata_hold_r <= '0;
      for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
    end else begin
      addr_hold_r  <= mem_addr;
      wdata_hold_r <= mem_wdata;
      case (state_r)
        S_FETCH: begin
          if (mem_ready) begin
            ir_r <= mem_rdata[15:0];
            pc_r <= pc_r + PC_INC;
          end
        end
        S_DECODE: begin
          a_r <= use_ra_s ? regs_r[ra_s] : regs_r[rb_s];
          b_r <= (op_s == OP_SW) ? regs_r[rb_s] : regs_r[rc_s];
        end
        S_EXEC: begin
          alu_out_r <= alu_s;
          if (taken_s) pc_r <= target_s;
        end
        S_MEM: begin
          if (mem_ready && (op_s == OP_LW)) mdr_r <= mem_rdata;
        end
        S_WB: begin
          // r0 is never written, so it keeps reading zero
          if (ra_s != '0) regs_r[ra_s] <= (op_s == OP_LW) ? mdr_r : alu_out_r;
        end
        default: ;
      endcase
    end
  end

  // Memory port; request is gated by rst so reset drops it without waiting for a clock.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_hold_r;
    mem_wdata = wdata_hold_r;
    if (state_r == S_FETCH) begin
      mem_req  = rst;
      mem_addr = pc_r;
    end else if (state_r == S_MEM) begin
      mem_req  = rst;
      mem_we   = rst & (op_s == OP_SW);
      mem_addr = alu_out_r[AW-1:0];
      if (op_s == OP_SW) mem_wdata = a_r;
      else               mem_wdata = wdata_hold_r;
    end else begin
      mem_req = 1'b0;
    end
  end

  assign halted    = (state_r == S_HALT);
  assign state_dbg = state_r;

`ifdef MC_CORE_PERF_EN
  logic        retire_s;
  logic [31:0] cyc_cnt_r, ret_cnt_r;

  // An instruction retires on the transition out of its final state.
  always_comb begin
    retire_s = ((state_r == S_EXEC) && ((state_n == S_FETCH) || (state_n == S_HALT))) ||
               ((state_r == S_MEM) && (state_n == S_FETCH)) ||
               (state_r == S_WB);
  end

  // Free-running performance counters, frozen once halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_r <= 32'd0;
      ret_cnt_r <= 32'd0;
    end else begin
      if (state_r != S_HALT) cyc_cnt_r <= cyc_cnt_r + 32'd1;
      if (retire_s)          ret_cnt_r <= ret_cnt_r + 32'd1;
    end
  end

  assign perf_cycles  = cyc_cnt_r;
  assign perf_retired = ret_cnt_r;
`else
  assign perf_cycles  = 32'd0;
  assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_mc_core_param.sv
// Directed testbench for mc_core_param (DW=32, AW=16, NREG=8, RESET_PC=0x0010)
// with a word-addressed memory model that inserts a programmable number of wait states.
module tb_mc_core_param;

  localparam int DW = 32;
  localparam int AW = 16;
`ifdef MC_CORE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req, mem_we, mem_ready, halted;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [2:0]    state_dbg;
  logic [31:0]   perf_cycles, perf_retired;

  mc_core_param #(.DW(DW), .AW(AW), .NREG(8), .RESET_PC(16'h0010)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .state_dbg(state_dbg),
    .perf_cycles(perf_cycles), .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  // memory model state
  logic [31:0] mem [256];
  int          wait_n = 0;
  int          wcnt = 0;
  int          cyc = 0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = 8'h00;
  logic [31:0] ld_data = 32'h0;
  int          wr_n = 0;
  logic [15:0] wr_addr = 16'h0;
  logic [31:0] wr_data = 32'h0;
  int          fetch_n = 0;
  logic [15:0] fetch_addr [1024];
  int          fetch_cyc [1024];
  int          stab_err = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic        prev_we = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ready = mem_req && (wcnt == wait_n);

  // Memory responder: program loads, stores, fetch log, wait states, stability watch.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_n    <= wr_n + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (mem_req && !mem_we && mem_ready && state_dbg == 3'd0 && fetch_n < 1024) begin
      fetch_addr[fetch_n] <= mem_addr;
      fetch_cyc[fetch_n]  <= cyc;
      fetch_n             <= fetch_n + 1;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (prev_wait && mem_req && (mem_addr != prev_addr || mem_we != prev_we))
      stab_err <= stab_err + 1;
    prev_wait <= mem_req && !mem_ready;
    prev_addr <= mem_addr;
    prev_we   <= mem_we;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic run_until_halt(input int limit, output int n);
    n = 0;
    while (!halted && n < limit) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fb, wb, sb;
    logic [15:0] exp_tr [7];

    // ---------------- reset state + ALU sequence, zero wait ----------------
    rst = 1'b0;
    wait_n = 0;
    enter_reset();
    load_word(8'h10, 32'h4105);   // ADDI r1,5
    load_word(8'h11, 32'h42FD);   // ADDI r2,-3
    load_word(8'h12, 32'h0312);   // ADD r3,r1,r2
    load_word(8'h13, 32'hF000);   // HALT
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_state", state_dbg, 0);
    check_eq("rst_perf_cyc", perf_cycles, 0);
    check_eq("rst_perf_ret", perf_retired, 0);
    release_reset();
    check_eq("rv_mem_req", mem_req, 1);
    check_eq("rv_mem_addr", mem_addr, 16'h0010);
    check_eq("rv_mem_we", mem_we, 0);
    check_eq("rv_state", state_dbg, 0);
    run_until_halt(100, n);
    check_eq("alu_cycles", n, 15);
    check_eq("alu_r1", dut.regs_r[1], 32'h5);
    check_eq("alu_r2", dut.regs_r[2], 32'hFFFF_FFFD);
    check_eq("alu_r3", dut.regs_r[3], 32'h2);
    check_eq("alu_perf_ret", perf_retired, PERF ? 32'd4 : 32'd0);
    check_eq("alu_perf_cyc", perf_cycles, PERF ? 32'd15 : 32'd0);
    repeat (3) @(negedge clk);
    check_eq("halt_state", state_dbg, 5);
    check_eq("halt_no_req", mem_req, 0);
    check_eq("halt_perf_frozen", perf_cycles, PERF ? 32'd15 : 32'd0);

    // ---------------- load/store with 2 wait states ----------------
    enter_reset();
    wait_n = 2;
    load_word(8'h30, 32'hBEEF);
    load_word(8'h40, 32'h0);
    load_word(8'h10, 32'h4130);   // ADDI r1,0x30
    load_word(8'h11, 32'h5210);   // LW r2,r1
    load_word(8'h12, 32'h4110);   // ADDI r1,0x10 -> 0x40
    load_word(8'h13, 32'h6210);   // SW r2,r1
    load_word(8'h14, 32'h5410);   // LW r4,r1
    load_word(8'h15, 32'hF000);   // HALT
    fb = fetch_n;
    wb = wr_n;
    sb = stab_err;
    release_reset();
    run_until_halt(300, n);
    check_eq("ls_cycles", n, 43);
    check_eq("ls_writes", wr_n - wb, 1);
    check_eq("ls_wr_addr", wr_addr, 16'h0040);
    check_eq("ls_wr_data", wr_data, 32'hBEEF);
    check_eq("ls_r2", dut.regs_r[2], 32'hBEEF);
    check_eq("ls_r4", dut.regs_r[4], 32'hBEEF);
    check_eq("ls_sw_len", fetch_cyc[fb+4] - fetch_cyc[fb+3], 8);
    check_eq("ls_lw_len", fetch_cyc[fb+5] - fetch_cyc[fb+4], 9);
    check_eq("ls_stable", stab_err - sb, 0);
    check_eq("ls_perf_ret", perf_retired, PERF ? 32'd6 : 32'd0);
    check_eq("ls_perf_cyc", perf_cycles, PERF ? 32'd43 : 32'd0);

    // ---------------- branches, jumps, r0 write ----------------
    enter_reset();
    wait_n = 0;
    load_word(8'h10, 32'h7102);   // BEQZ r1,+2 -> 0x13
    load_word(8'h11, 32'h4101);   // skipped
    load_word(8'h12, 32'h4101);   // skipped
    load_word(8'h13, 32'h8102);   // BNEZ r1,+2 falls through
    load_word(8'h14, 32'h4007);   // ADDI r0,7 (ignored)
    load_word(8'h15, 32'h900A);   // JMP +10 -> 0x20
    load_word(8'h20, 32'h9FFF);   // JMP -1 -> 0x20
    fb = fetch_n;
    exp_tr = '{16'h0010, 16'h0013, 16'h0014, 16'h0015, 16'h0020, 16'h0020, 16'h0020};
    release_reset();
    n = 0;
    while (fetch_n < fb + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("br_fetch_count", (fetch_n >= fb + 7), 1);
    for (int i = 0; i < 7; i++) check_eq($sformatf("br_trace%0d", i), fetch_addr[fb+i], exp_tr[i]);
    check_eq("br_r0", dut.regs_r[0], 0);
    check_eq("br_r1", dut.regs_r[1], 0);
    check_eq("br_not_halted", halted, 0);

    // ---------------- width / wrap, register field 9 -> r1 ----------------
    enter_reset();
    load_word(8'h00, 32'h0);
    load_word(8'h01, 32'hDEAD);
    load_word(8'h10, 32'h49FF);   // ADDI r9(=r1),-1
    load_word(8'h11, 32'h6100);   // SW r1,r0 -> mem[0]
    load_word(8'h12, 32'h4101);   // ADDI r1,1 -> 0
    load_word(8'h13, 32'h4201);   // ADDI r2,1
    load_word(8'h14, 32'h6120);   // SW r1,r2 -> mem[1]
    load_word(8'h15, 32'hF000);
    release_reset();
    run_until_halt(100, n);
    check_eq("wr_cycles", n, 23);
    check_eq("wr_minus1", mem[0], 32'hFFFF_FFFF);
    check_eq("wr_wrap0", mem[1], 32'h0);
    check_eq("wr_r1", dut.regs_r[1], 32'h0);

    // ---------------- reset while SW waits in MEM ----------------
    enter_reset();
    wait_n = 3;
    load_word(8'h40, 32'h55);
    load_word(8'h10, 32'h4140);   // ADDI r1,0x40
    load_word(8'h11, 32'h4209);   // ADDI r2,9
    load_word(8'h12, 32'h6210);   // SW r2,r1
    load_word(8'h13, 32'hF000);
    wb = wr_n;
    release_reset();
    n = 0;
    while (!(state_dbg == 3'd3 && mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("mr_reached_mem", (state_dbg == 3'd3 && mem_we && !mem_ready), 1);
    #2 rst = 1'b0;
    #1;
    check_eq("mr_req_drop", mem_req, 0);
    check_eq("mr_we_drop", mem_we, 0);
    check_eq("mr_state", state_dbg, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("mr_no_write", wr_n - wb, 0);
    check_eq("mr_mem_intact", mem[8'h40], 32'h55);
    check_eq("mr_r1_cleared", dut.regs_r[1], 0);
    release_reset();
    check_eq("mr_refetch_req", mem_req, 1);
    check_eq("mr_refetch_addr", mem_addr, 16'h0010);
    check_eq("mr_refetch_we", mem_we, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
